// File: rtl/crc_mem_checker.sv
// crc_mem_checker: fetches a block of words from synchronous memory,
// folds them into a parametrised CRC and compares the result to a target.
// Ports:
//   clk50m, rst_n                : clock, async active-low reset
//   crc_start, crc_abort         : run control (start sampled only in IDLE)
//   start_addr, length           : block to check (length clamped to 2^ADDR_W)
//   mem_addr, mem_rd, mem_data   : memory read port (data MEM_LAT cycles after rd)
//   crc_target                   : expected CRC
//   crc_busy, crc_rdy            : status, one-cycle done pulse
//   crc_ok, crc_out              : compare result and final CRC
module crc_mem_checker #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = 16'h8005,
  parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOR_OUT = 16'hFFFF,
  parameter int unsigned REFLECT = 1,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk50m,
  input  logic              rst_n,
  input  logic              crc_start,
  input  logic              crc_abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [CRC_W-1:0]  crc_target,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              crc_busy,
  output logic              crc_rdy,
  output logic              crc_ok,
  output logic [CRC_W-1:0]  crc_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FINAL = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rd_q;
  logic [ADDR_W:0]     cnt_q;
  logic [MEM_LAT-1:0]  vld_q;
  logic [MEM_LAT-1:0]  vld_d;
  logic [CRC_W-1:0]    crc_q;
  logic [CRC_W-1:0]    crc_d;
  logic [CRC_W-1:0]    out_q;
  logic                ok_q;
  logic [CRC_W-1:0]    fin;
  logic [ADDR_W:0]     len_cl;

  // One whole word per call; reflected mode shifts right with the
  // bit-reversed polynomial and consumes data LSB first.
  function automatic logic [CRC_W-1:0] crc_step(
    input logic [CRC_W-1:0]  c,
    input logic [DATA_W-1:0] d
  );
    logic [CRC_W-1:0] r;
    logic [CRC_W-1:0] pr;
    logic             fb;
    r = c;
    for (int i = 0; i < CRC_W; i++) pr[i] = POLY[CRC_W-1-i];
    for (int i = 0; i < DATA_W; i++) begin
      if (REFLECT != 0) begin
        fb = r[0] ^ d[i];
        r  = r >> 1;
        if (fb) r = r ^ pr;
      end else begin
        fb = r[CRC_W-1] ^ d[DATA_W-1-i];
        r  = r << 1;
        if (fb) r = r ^ POLY;
      end
    end
    return r;
  endfunction

  always_comb begin
    len_cl = (length > MAX_LEN) ? MAX_LEN : length;
    // Next contents of the read-tracking pipe: shift in this cycle's strobe.
    vld_d  = MEM_LAT'({vld_q, rd_q});
    crc_d  = vld_q[MEM_LAT-1] ? crc_step(crc_q, mem_data) : crc_q;
    fin    = crc_q ^ XOR_OUT;
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= '0;
      crc_q   <= INIT;
      out_q   <= '0;
      ok_q    <= 1'b0;
    end else if (state_q != IDLE && crc_abort) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= '0;
      crc_q   <= INIT;
      out_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      vld_q <= vld_d;
      crc_q <= crc_d;
      unique case (state_q)
        IDLE: begin
          if (crc_start && !crc_abort) begin
            addr_q <= start_addr;
            cnt_q  <= len_cl;
            crc_q  <= INIT;
            out_q  <= '0;
            ok_q   <= 1'b0;
            if (len_cl == '0) begin
              state_q <= FINAL;
            end else begin
              state_q <= FETCH;
              rd_q    <= 1'b1;
            end
          end
        end
        FETCH: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == 1) begin
            rd_q    <= 1'b0;
            state_q <= DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (vld_d == '0) state_q <= FINAL;
        end
        FINAL: begin
          out_q   <= fin;
          ok_q    <= (fin == crc_target);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result is presented during FINAL itself so it lines up with crc_rdy,
  // then held from the registers until the next accepted start.
  assign mem_addr = addr_q;
  assign mem_rd   = rd_q;
  assign crc_busy = (state_q != IDLE);
  assign crc_rdy  = (state_q == FINAL);
  assign crc_out  = (state_q == FINAL) ? fin : out_q;
  assign crc_ok   = (state_q == FINAL) ? (fin == crc_target) : ok_q;

endmodule

// File: tb/tb_crc_mem_checker.sv
// tb_crc_mem_checker: directed bench for crc_mem_checker, one default
// (CRC-16/USB) instance and one CRC-16/CCITT-FALSE instance, MEM_LAT=3.
module tb_crc_mem_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        crc_start = 1'b0;
  logic        crc_abort = 1'b0;
  logic [9:0]  start_addr = '0;
  logic [10:0] length = '0;
  logic [15:0] crc_target = '0;

  logic [7:0]  a_data, b_data;
  logic [9:0]  a_addr, b_addr;
  logic        a_rd, b_rd, a_busy, b_busy, a_rdy, b_rdy, a_ok, b_ok;
  logic [15:0] a_out, b_out;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  crc_mem_checker u_dut_a (
    .clk50m(clk), .rst_n(rst_n),
    .crc_start(crc_start), .crc_abort(crc_abort),
    .start_addr(start_addr), .length(length),
    .mem_data(a_data), .crc_target(crc_target),
    .mem_addr(a_addr), .mem_rd(a_rd),
    .crc_busy(a_busy), .crc_rdy(a_rdy),
    .crc_ok(a_ok), .crc_out(a_out)
  );

  crc_mem_checker #(
    .REFLECT(0), .POLY(16'h1021), .INIT(16'hFFFF),
    .XOR_OUT(16'h0000), .MEM_LAT(3)
  ) u_dut_b (
    .clk50m(clk), .rst_n(rst_n),
    .crc_start(crc_start), .crc_abort(crc_abort),
    .start_addr(start_addr), .length(length),
    .mem_data(b_data), .crc_target(crc_target),
    .mem_addr(b_addr), .mem_rd(b_rd),
    .crc_busy(b_busy), .crc_rdy(b_rdy),
    .crc_ok(b_ok), .crc_out(b_out)
  );

  logic [7:0] mem [0:1023];
  logic [7:0] pa;
  logic [7:0] pb [0:2];

  always @(posedge clk) begin
    pa    <= mem[a_addr];
    pb[0] <= mem[b_addr];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign a_data = pa;
  assign b_data = pb[2];

  int          rda_cyc[$];
  logic [9:0]  rda_addr[$];
  int          rdya_cyc[$];
  logic [15:0] rdya_out[$];
  logic        rdya_ok[$];
  int          rdyb_cyc[$];
  logic [15:0] rdyb_out[$];
  logic        rdyb_ok[$];
  logic        ab_rd, ab_busy;
  logic [15:0] fin_out_a;
  logic        fin_ok_a;

  // Cycle 0 is the cycle in which crc_start is sampled; everything is
  // sampled and driven at the falling edge.
  task automatic run(input logic [9:0] sa, input logic [10:0] len,
                     input logic [15:0] tgt, input int abort_at,
                     input int restart_at, input int ncyc);
    rda_cyc.delete(); rda_addr.delete();
    rdya_cyc.delete(); rdya_out.delete(); rdya_ok.delete();
    rdyb_cyc.delete(); rdyb_out.delete(); rdyb_ok.delete();
    ab_rd = 1'bx; ab_busy = 1'bx;
    @(negedge clk);
    start_addr = sa; length = len; crc_target = tgt;
    crc_start = 1'b1; crc_abort = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (a_rd) begin rda_cyc.push_back(c); rda_addr.push_back(a_addr); end
      if (a_rdy) begin
        rdya_cyc.push_back(c); rdya_out.push_back(a_out); rdya_ok.push_back(a_ok);
      end
      if (b_rdy) begin
        rdyb_cyc.push_back(c); rdyb_out.push_back(b_out); rdyb_ok.push_back(b_ok);
      end
      if (c == abort_at + 1) begin ab_rd = a_rd; ab_busy = a_busy; end
      crc_start = (c == restart_at);
      crc_abort = (c == abort_at);
    end
    fin_out_a = a_out;
    fin_ok_a  = a_ok;
  endtask

  task automatic test_reset;
    #5;
    checks++; if (a_addr !== 10'h000) begin errors++; $display("FAIL reset_addr got %h want 000", a_addr); end
    checks++; if (a_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", a_rd); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a_busy); end
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", a_rdy); end
    checks++; if (a_ok !== 1'b0) begin errors++; $display("FAIL reset_ok got %b want 0", a_ok); end
    checks++; if (a_out !== 16'h0000) begin errors++; $display("FAIL reset_out got %h want 0000", a_out); end
    checks++; if (b_rd !== 1'b0) begin errors++; $display("FAIL reset_b_rd got %b want 0", b_rd); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_usb_match(input string tag);
    run(10'h010, 11'd9, 16'hB4C8, -1, -1, 20);
    checks++; if (rda_cyc.size() != 9) begin errors++; $display("FAIL %s_rd_count got %0d want 9", tag, rda_cyc.size()); end
    for (int i = 0; i < rda_cyc.size(); i++) begin
      checks++;
      if (rda_cyc[i] != i + 1 || rda_addr[i] !== 10'(16 + i)) begin
        errors++; $display("FAIL %s_rd[%0d] got cyc %0d addr %h want cyc %0d addr %h", tag, i, rda_cyc[i], rda_addr[i], i + 1, 10'(16 + i));
      end
    end
    checks++; if (rdya_cyc.size() != 1) begin errors++; $display("FAIL %s_rdy_count got %0d want 1", tag, rdya_cyc.size()); end
    else begin
      checks++; if (rdya_cyc[0] != 11) begin errors++; $display("FAIL %s_rdy_cyc got %0d want 11", tag, rdya_cyc[0]); end
      checks++; if (rdya_out[0] !== 16'hB4C8) begin errors++; $display("FAIL %s_out got %h want b4c8", tag, rdya_out[0]); end
      checks++; if (rdya_ok[0] !== 1'b1) begin errors++; $display("FAIL %s_ok got %b want 1", tag, rdya_ok[0]); end
    end
    checks++; if (fin_out_a !== 16'hB4C8 || fin_ok_a !== 1'b1) begin errors++; $display("FAIL %s_hold got %h/%b want b4c8/1", tag, fin_out_a, fin_ok_a); end
  endtask

  task automatic test_usb_mismatch;
    run(10'h010, 11'd9, 16'h1234, -1, -1, 20);
    checks++; if (rdya_cyc.size() != 1) begin errors++; $display("FAIL mis_rdy_count got %0d want 1", rdya_cyc.size()); end
    else begin
      checks++; if (rdya_cyc[0] != 11) begin errors++; $display("FAIL mis_rdy_cyc got %0d want 11", rdya_cyc[0]); end
      checks++; if (rdya_out[0] !== 16'hB4C8) begin errors++; $display("FAIL mis_out got %h want b4c8", rdya_out[0]); end
      checks++; if (rdya_ok[0] !== 1'b0) begin errors++; $display("FAIL mis_ok got %b want 0", rdya_ok[0]); end
    end
  endtask

  task automatic test_zero_len;
    run(10'h010, 11'd0, 16'h0000, -1, -1, 8);
    checks++; if (rda_cyc.size() != 0) begin errors++; $display("FAIL zero_rd_count got %0d want 0", rda_cyc.size()); end
    checks++; if (rdya_cyc.size() != 1) begin errors++; $display("FAIL zero_rdy_count got %0d want 1", rdya_cyc.size()); end
    else begin
      checks++; if (rdya_cyc[0] != 1) begin errors++; $display("FAIL zero_rdy_cyc got %0d want 1", rdya_cyc[0]); end
      checks++; if (rdya_out[0] !== 16'h0000) begin errors++; $display("FAIL zero_out got %h want 0000", rdya_out[0]); end
      checks++; if (rdya_ok[0] !== 1'b1) begin errors++; $display("FAIL zero_ok got %b want 1", rdya_ok[0]); end
    end
  endtask

  task automatic test_wrap_restart;
    logic [9:0] exp_a [4];
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
    run(10'h3FE, 11'd4, 16'h0000, -1, 3, 16);
    checks++; if (rda_cyc.size() != 4) begin errors++; $display("FAIL wrap_rd_count got %0d want 4", rda_cyc.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rda_addr[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %h want %h", i, rda_addr[i], exp_a[i]); end
      end
    end
    checks++; if (rdya_cyc.size() != 1) begin errors++; $display("FAIL wrap_rdy_count got %0d want 1", rdya_cyc.size()); end
    else begin
      checks++; if (rdya_cyc[0] != 6) begin errors++; $display("FAIL wrap_rdy_cyc got %0d want 6", rdya_cyc[0]); end
    end
  endtask

  task automatic test_abort;
    run(10'h010, 11'd9, 16'hB4C8, 4, -1, 20);
    checks++; if (ab_rd !== 1'b0) begin errors++; $display("FAIL abort_rd got %b want 0", ab_rd); end
    checks++; if (ab_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", ab_busy); end
    checks++; if (rdya_cyc.size() != 0) begin errors++; $display("FAIL abort_rdy_count got %0d want 0", rdya_cyc.size()); end
    checks++; if (fin_out_a !== 16'h0000) begin errors++; $display("FAIL abort_out got %h want 0000", fin_out_a); end
    checks++; if (fin_ok_a !== 1'b0) begin errors++; $display("FAIL abort_ok got %b want 0", fin_ok_a); end
    test_usb_match("rerun");
  endtask

  task automatic test_ccitt;
    run(10'h010, 11'd9, 16'h29B1, -1, -1, 20);
    checks++; if (rdyb_cyc.size() != 1) begin errors++; $display("FAIL ccitt_rdy_count got %0d want 1", rdyb_cyc.size()); end
    else begin
      checks++; if (rdyb_cyc[0] != 13) begin errors++; $display("FAIL ccitt_rdy_cyc got %0d want 13", rdyb_cyc[0]); end
      checks++; if (rdyb_out[0] !== 16'h29B1) begin errors++; $display("FAIL ccitt_out got %h want 29b1", rdyb_out[0]); end
      checks++; if (rdyb_ok[0] !== 1'b1) begin errors++; $display("FAIL ccitt_ok got %b want 1", rdyb_ok[0]); end
    end
  endtask

  task automatic test_length_clamp;
    run(10'h000, 11'h7FF, 16'h0000, -1, -1, 1030);
    checks++; if (rda_cyc.size() != 1024) begin errors++; $display("FAIL clamp_rd_count got %0d want 1024", rda_cyc.size()); end
    else begin
      checks++; if (rda_addr[1023] !== 10'h3FF) begin errors++; $display("FAIL clamp_last_addr got %h want 3ff", rda_addr[1023]); end
    end
    checks++; if (rdya_cyc.size() != 1) begin errors++; $display("FAIL clamp_rdy_count got %0d want 1", rdya_cyc.size()); end
    else begin
      checks++; if (rdya_cyc[0] != 1026) begin errors++; $display("FAIL clamp_rdy_cyc got %0d want 1026", rdya_cyc[0]); end
    end
  endtask

  task automatic test_reset_midrun;
    int nrdy;
    nrdy = 0;
    @(negedge clk);
    start_addr = 10'h010; length = 11'd9; crc_target = 16'hB4C8; crc_start = 1'b1;
    @(negedge clk);
    crc_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #2;
    checks++; if (a_rd !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL midrst_rd_busy got %b/%b want 0/0", a_rd, a_busy); end
    checks++; if (a_out !== 16'h0000 || a_addr !== 10'h000) begin errors++; $display("FAIL midrst_out_addr got %h/%h want 0000/000", a_out, a_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (a_rdy) nrdy++;
    end
    checks++; if (nrdy != 0) begin errors++; $display("FAIL midrst_rdy got %0d pulses want 0", nrdy); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 9; i++) mem[16 + i] = 8'(8'h31 + i);
    test_reset();
    test_usb_match("usb");
    test_usb_mismatch();
    test_zero_len();
    test_wrap_restart();
    test_abort();
    test_ccitt();
    test_length_clamp();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_mem_checker.md
Name: crc_mem_checker

Overview:
Parametrised CRC engine with its own memory fetch controller. On a start pulse it reads a programmable number of words from a programmable start address in synchronous memory with configurable read latency. It folds each word into a CRC whose width, polynomial, init value, output XOR and bit order are set by parameters, then compares the result against a target value. It is the generalised successor of the fixed CRC-16/USB, fixed-range checker and sits between the memory and the system control logic.

Parameters:
ADDR_W, 10, memory address width
DATA_W, 8, memory word width; all DATA_W bits are processed per word in one cycle
CRC_W, 16, CRC register width
POLY, 16'h8005, generator polynomial in normal (non-reflected) form, CRC_W bits
INIT, 16'hFFFF, CRC register value at start
XOR_OUT, 16'hFFFF, value XORed onto the final register
REFLECT, 1, 1 = LSB-first input, right-shifting register with bit-reversed POLY; 0 = MSB-first, left-shifting
MEM_LAT, 1, memory read latency in cycles, legal range 1..4

Ports:
clk50m  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
crc_start  in  1  start request, sampled only in IDLE
crc_abort  in  1  abort the current run
start_addr  in  ADDR_W  first word address, latched at start
length  in  ADDR_W+1  number of words, 0..2^ADDR_W; larger values are clamped to 2^ADDR_W
mem_data  in  DATA_W  read data, valid MEM_LAT cycles after mem_rd
crc_target  in  CRC_W  expected CRC, sampled in FINAL
mem_addr  out  ADDR_W  read address
mem_rd  out  1  read strobe
crc_busy  out  1  high in FETCH, DRAIN and FINAL
crc_rdy  out  1  one-cycle done pulse
crc_ok  out  1  crc_out == crc_target, valid from crc_rdy until the next accepted start
crc_out  out  CRC_W  final CRC

Behaviour:
- Reset (async assert, sync release): state IDLE; mem_addr, mem_rd, crc_busy, crc_rdy, crc_ok and crc_out are 0; the valid pipeline is cleared.
- States: IDLE, FETCH, DRAIN, FINAL.
- IDLE: when crc_start=1 and crc_abort=0, latch start_addr and the clamped length, load CRC register with INIT, clear crc_ok and crc_out. If length=0, go to FINAL; otherwise go to FETCH.
- FETCH: mem_rd=1 for exactly N consecutive cycles. mem_addr = (start_addr + i) mod 2^ADDR_W for i = 0..N-1, so it wraps from 2^ADDR_W-1 to 0. After the last issue, go to DRAIN.
- A MEM_LAT-deep valid shift register tracks outstanding reads. Each valid mem_data word updates the CRC register in the same cycle it arrives.
- DRAIN: stay until the pipeline is empty, then go to FINAL.
- FINAL (one cycle):
  - crc_out <= reg ^ XOR_OUT
  - crc_ok <= ((reg ^ XOR_OUT) == crc_target)
  - crc_rdy = 1
  - next state is IDLE
- crc_out and crc_ok hold their values in IDLE.
- Latency: crc_start sampled in cycle 0. mem_rd is high in cycles 1..N. crc_rdy is high in cycle N+MEM_LAT+1 for N>0, and in cycle 1 for N=0.
- crc_start while busy is ignored; there is no queuing.
- crc_abort=1 sampled in any state other than IDLE: next cycle the state is IDLE and mem_rd=0. No crc_rdy is produced, crc_ok=0, crc_out=0, and in-flight read data is discarded. Abort and start in the same IDLE cycle: abort wins and the start is dropped.
- mem_addr holds its last value in IDLE.
- rst_n asserted mid-run: immediate return to reset values; no crc_rdy.

Test Plan:
1. Defaults (CRC-16/USB). Memory 0x010..0x018 holds ASCII "123456789"; start_addr=0x010, length=9, target=0xB4C8. Required: mem_rd high cycles 1..9 with addresses 0x010..0x018; crc_rdy in cycle 11; crc_out=0xB4C8; crc_ok=1.
2. Same data, target=0x1234. Required: crc_out=0xB4C8, crc_ok=0, single crc_rdy pulse in cycle 11.
3. length=0, target=0x0000. Required: mem_rd never asserted; crc_rdy in cycle 1; crc_out=0x0000 (INIT^XOR_OUT); crc_ok=1.
4. Wrap: start_addr=0x3FE, length=4. Required: address sequence 0x3FE, 0x3FF, 0x000, 0x001. crc_start pulsed again at cycle 3: ignored, exactly one crc_rdy.
5. Abort: length=9, crc_abort pulsed in cycle 4. Required: mem_rd=0 and crc_busy=0 in cycle 5; no crc_rdy; crc_ok=0, crc_out=0. A following normal run reproduces scenario 1 exactly.
6. REFLECT=0, POLY=16'h1021, INIT=16'hFFFF, XOR_OUT=0, MEM_LAT=3, data "123456789", target=0x29B1. Required: crc_rdy in cycle 13; crc_out=0x29B1; crc_ok=1.
